// File: rtl/addr_fifo_defs.sv
// rtl/addr_fifo_defs.sv - shared constants and helpers for the address FIFO
package addr_fifo_defs;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    function automatic int fifo_depth(input int depth_width);
        return 1 << depth_width;
    endfunction

    function automatic int level_width(input int depth_width);
        return depth_width + 1;
    endfunction

endpackage

// File: rtl/addr_fifo_sdpram.sv
// rtl/addr_fifo_sdpram.sv - simple dual-port RAM, sync write, registered read with enable
module addr_fifo_sdpram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    // Array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/addr_sync_fifo.sv
// rtl/addr_sync_fifo.sv - single-clock address FIFO with standard/FWFT read, flush and error flags
module addr_sync_fifo
    import addr_fifo_defs::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int DEPTH_WIDTH      = 11,
    parameter int FWFT             = FWFT_OFF,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  err_clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_empty,
    output logic                  almost_empty,
    output logic [DEPTH_WIDTH:0]  water_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = fifo_depth(DEPTH_WIDTH);
    localparam int LVL_W = level_width(DEPTH_WIDTH);

    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(ALMOST_FULL_NUM);
    localparam logic [LVL_W-1:0] LVL_AE   = LVL_W'(ALMOST_EMPTY_NUM);

    if (ALMOST_FULL_NUM < 1 || ALMOST_FULL_NUM > DEPTH) begin : g_bad_almost_full
        $error("addr_sync_fifo: ALMOST_FULL_NUM=%0d outside 1..%0d", ALMOST_FULL_NUM, DEPTH);
    end
    if (ALMOST_EMPTY_NUM < 0 || ALMOST_EMPTY_NUM >= DEPTH) begin : g_bad_almost_empty
        $error("addr_sync_fifo: ALMOST_EMPTY_NUM=%0d outside 0..%0d", ALMOST_EMPTY_NUM, DEPTH - 1);
    end
    if (FWFT != FWFT_OFF && FWFT != FWFT_ON) begin : g_bad_fwft
        $error("addr_sync_fifo: FWFT=%0d must be 0 or 1", FWFT);
    end

    logic [LVL_W-1:0] wptr;
    logic [LVL_W-1:0] rptr;
    logic [LVL_W-1:0] mem_count;
    logic             out_valid;
    logic             wr_acc;
    logic             rd_acc;
    logic             fetch;

    assign wr_full      = (water_level == LVL_FULL);
    assign almost_full  = (water_level >= LVL_AF);
    assign almost_empty = (water_level <= LVL_AE);
    assign rd_empty     = (FWFT == FWFT_ON) ? ~out_valid : (water_level == '0);

    assign wr_acc    = wr_en & ~wr_full & ~flush;
    assign rd_acc    = rd_en & ~rd_empty & ~flush;
    assign mem_count = wptr - rptr;

    // In FWFT mode the RAM output register is the visible head stage; it is
    // refilled whenever it is empty or being popped and the array holds a word.
    assign fetch = (FWFT == FWFT_ON)
                 ? (~flush & (mem_count != '0) & (~out_valid | rd_acc))
                 : rd_acc;

    addr_fifo_sdpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .wr_en   (wr_acc),
        .wr_addr (wptr[DEPTH_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (fetch),
        .rd_addr (rptr[DEPTH_WIDTH-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            water_level <= '0;
            out_valid   <= 1'b0;
        end else if (flush) begin
            wptr        <= '0;
            rptr        <= '0;
            water_level <= '0;
            out_valid   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + LVL_ONE;
            end
            if (fetch) begin
                rptr <= rptr + LVL_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   water_level <= water_level + LVL_ONE;
                2'b01:   water_level <= water_level - LVL_ONE;
                default: water_level <= water_level;
            endcase
            if (FWFT == FWFT_ON) begin
                if (fetch) begin
                    out_valid <= 1'b1;
                end else if (rd_acc) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    // Requests dropped by a flush are not errors; err_clr wins over a new set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & wr_full & ~flush) begin
                overflow <= 1'b1;
            end
            if (rd_en & rd_empty & ~flush) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_addr_sync_fifo.sv
// tb/tb_addr_sync_fifo.sv - directed self-checking bench for addr_sync_fifo in both read modes
module tb_addr_sync_fifo;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic        flush;
    logic        err_clr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wr_data;

    logic        s_wr_full, s_af, s_rd_empty, s_ae, s_ovf, s_udf;
    logic [31:0] s_rd_data;
    logic [4:0]  s_level;
    logic        f_wr_full, f_af, f_rd_empty, f_ae, f_ovf, f_udf;
    logic [31:0] f_rd_data;
    logic [4:0]  f_level;

    logic        o_wr_full, o_af, o_rd_empty, o_ae, o_ovf, o_udf;
    logic [31:0] o_rd_data;
    logic [4:0]  o_level;

    int checks = 0;
    int errors = 0;

    addr_sync_fifo #(
        .DATA_WIDTH(32), .DEPTH_WIDTH(4), .FWFT(0), .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)
    ) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush & ~mode), .err_clr(err_clr & ~mode),
        .wr_en(wr_en & ~mode), .wr_data(wr_data), .wr_full(s_wr_full), .almost_full(s_af),
        .rd_en(rd_en & ~mode), .rd_data(s_rd_data), .rd_empty(s_rd_empty), .almost_empty(s_ae),
        .water_level(s_level), .overflow(s_ovf), .underflow(s_udf)
    );

    addr_sync_fifo #(
        .DATA_WIDTH(32), .DEPTH_WIDTH(4), .FWFT(1), .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush & mode), .err_clr(err_clr & mode),
        .wr_en(wr_en & mode), .wr_data(wr_data), .wr_full(f_wr_full), .almost_full(f_af),
        .rd_en(rd_en & mode), .rd_data(f_rd_data), .rd_empty(f_rd_empty), .almost_empty(f_ae),
        .water_level(f_level), .overflow(f_ovf), .underflow(f_udf)
    );

    always_comb begin
        o_wr_full  = mode ? f_wr_full  : s_wr_full;
        o_af       = mode ? f_af       : s_af;
        o_rd_empty = mode ? f_rd_empty : s_rd_empty;
        o_ae       = mode ? f_ae       : s_ae;
        o_ovf      = mode ? f_ovf      : s_ovf;
        o_udf      = mode ? f_udf      : s_udf;
        o_rd_data  = mode ? f_rd_data  : s_rd_data;
        o_level    = mode ? f_level    : s_level;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic w, input logic r, input logic [31:0] d);
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_rd_data"}, o_rd_data, 0);
        chk({p, "_rd_empty"}, o_rd_empty, 1);
        chk({p, "_wr_full"}, o_wr_full, 0);
        chk({p, "_almost_full"}, o_af, 0);
        chk({p, "_almost_empty"}, o_ae, 1);
        chk({p, "_level"}, o_level, 0);
        chk({p, "_overflow"}, o_ovf, 0);
        chk({p, "_underflow"}, o_udf, 0);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] exp_d;
        int          nw;
        logic        w, r;

        rst_n = 1'b0; mode = 1'b0; flush = 1'b0; err_clr = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        tick(); tick();
        chk_reset("reset_std");
        mode = 1'b1;
        chk_reset("reset_fwft");
        mode = 1'b0;
        rst_n = 1'b1;
        tick();

        // 1: fill and drain in standard mode
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 32'h100 + 32'(i));
            chk("s1_level", o_level, 64'(i + 1));
            chk("s1_almost_full", o_af, (i + 1 >= 14) ? 1 : 0);
            chk("s1_wr_full", o_wr_full, (i + 1 == 16) ? 1 : 0);
            chk("s1_almost_empty", o_ae, (i + 1 <= 2) ? 1 : 0);
        end
        chk("s1_not_empty", o_rd_empty, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 32'h0);
            chk("s1_rd_data", o_rd_data, 64'(32'h100 + 32'(i)));
            chk("s1_drain_level", o_level, 64'(15 - i));
        end
        chk("s1_rd_empty_end", o_rd_empty, 1);
        chk("s1_almost_empty_end", o_ae, 1);
        chk("s1_underflow", o_udf, 0);

        // 3: full with simultaneous write/read, then error flags
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 32'h200 + 32'(i));
        chk("s3_full", o_wr_full, 1);
        cyc(1'b1, 1'b1, 32'hDEAD);
        chk("s3_level", o_level, 15);
        chk("s3_overflow", o_ovf, 1);
        chk("s3_rd_data", o_rd_data, 32'h200);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("s3_ovf_cleared", o_ovf, 0);
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 1'b1, 32'h0);
            chk("s3_drain_data", o_rd_data, 64'(32'h200 + 32'(i)));
        end
        cyc(1'b0, 1'b1, 32'h0);
        chk("s3_underflow", o_udf, 1);
        chk("s3_rd_data_hold", o_rd_data, 32'h20F);
        chk("s3_level_zero", o_level, 0);
        err_clr = 1'b1; rd_en = 1'b1; tick(); err_clr = 1'b0; rd_en = 1'b0;
        chk("s3_clr_priority", o_udf, 0);

        // 2: FWFT latency, no-bubble pops and full capacity
        mode = 1'b1;
        cyc(1'b1, 1'b0, 32'hA5A5);
        chk("s2_empty_after_n", o_rd_empty, 1);
        chk("s2_level_after_n", o_level, 1);
        tick();
        chk("s2_visible_n1", o_rd_empty, 0);
        chk("s2_data_n1", o_rd_data, 32'hA5A5);
        cyc(1'b0, 1'b1, 32'h0);
        chk("s2_empty_after_pop", o_rd_empty, 1);
        chk("s2_level_after_pop", o_level, 0);
        chk("s2_data_hold", o_rd_data, 32'hA5A5);
        cyc(1'b1, 1'b0, 32'h11);
        cyc(1'b1, 1'b0, 32'h22);
        cyc(1'b1, 1'b0, 32'h33);
        chk("s2_head", o_rd_data, 32'h11);
        chk("s2_level3", o_level, 3);
        rd_en = 1'b1;
        tick(); chk("s2_pop2", o_rd_data, 32'h22);
        tick(); chk("s2_pop3", o_rd_data, 32'h33);
        tick(); rd_en = 1'b0;
        chk("s2_btb_empty", o_rd_empty, 1);
        chk("s2_btb_level", o_level, 0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 32'h300 + 32'(i));
        chk("s2_fwft_full", o_wr_full, 1);
        chk("s2_fwft_level16", o_level, 16);
        for (int i = 0; i < 16; i++) begin
            chk("s2_fwft_drain", o_rd_data, 64'(32'h300 + 32'(i)));
            cyc(1'b0, 1'b1, 32'h0);
        end
        chk("s2_fwft_empty_end", o_rd_empty, 1);
        mode = 1'b0;

        // 4: wrap-around with level kept in a band, checked against a queue
        nw = 0;
        for (int i = 0; i < 5; i++) begin
            q.push_back(32'h400 + 32'(nw));
            cyc(1'b1, 1'b0, 32'h400 + 32'(nw));
            nw++;
        end
        for (int k = 0; k < 200 && (nw < 40 || q.size() > 0); k++) begin
            w = (nw < 40) && (k % 3 != 2) && (q.size() < 10);
            r = (q.size() > 0) && (((k % 3 != 0) && q.size() > 3) || nw >= 40);
            exp_d = r ? q.pop_front() : 32'h0;
            if (w) begin
                q.push_back(32'h400 + 32'(nw));
            end
            cyc(w, r, 32'h400 + 32'(nw));
            if (w) nw++;
            if (r) chk("s4_data", o_rd_data, exp_d);
            chk("s4_level", o_level, 64'(q.size()));
        end
        chk("s4_all_written", nw, 40);
        chk("s4_empty", o_rd_empty, 1);

        // 5: flush at level 9 together with a write
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 32'h500 + 32'(i));
        cyc(1'b0, 1'b1, 32'h0);
        chk("s5_pre_level", o_level, 9);
        chk("s5_pre_data", o_rd_data, 32'h500);
        flush = 1'b1;
        cyc(1'b1, 1'b0, 32'hBAD);
        flush = 1'b0;
        chk("s5_level", o_level, 0);
        chk("s5_rd_empty", o_rd_empty, 1);
        chk("s5_rd_data", o_rd_data, 0);
        chk("s5_overflow", o_ovf, 0);
        chk("s5_underflow", o_udf, 0);
        flush = 1'b1;
        cyc(1'b0, 1'b1, 32'h0);
        flush = 1'b0;
        chk("s5_flush_rd_no_udf", o_udf, 0);
        cyc(1'b1, 1'b0, 32'h5A5A);
        chk("s5_post_level", o_level, 1);
        cyc(1'b0, 1'b1, 32'h0);
        chk("s5_post_data", o_rd_data, 32'h5A5A);

        // 6: asynchronous reset in the middle of a write burst
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 32'h600 + 32'(i));
        chk("s6_level7", o_level, 7);
        wr_en = 1'b1; wr_data = 32'h77;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset("s6_async");
        wr_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        cyc(1'b1, 1'b0, 32'h6161);
        chk("s6_post_level", o_level, 1);
        cyc(1'b0, 1'b1, 32'h0);
        chk("s6_post_data", o_rd_data, 32'h6161);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
